game_pixel_renderer: RTL and testbench

Pixel source for the 640x480 VGA path: answers the display driver's per-pixel coordinate request (next_x/next_y) with an 8-bit color_in value. It composites background, player, three enemies and the projectile from game-grid positions. Object positions are snapshotted once per frame so a frame never tears. It sits between the game-logic state registers and the vga_driver, on the 25 MHz pixel clock.

---
 rtl/render_pkg.sv | 41 ++++
 rtl/game_pixel_renderer_if.sv | 9 +
 rtl/sprite_hit.sv | 32 +++
 rtl/game_pixel_renderer.sv | 168 ++++++++++++++++
 tb/tb_game_pixel_renderer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/render_pkg.sv
// Shared constants, state encodings and types for the game pixel renderer.
package render_pkg;

    localparam int GRID_W   = 160;
    localparam int GRID_H   = 120;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [7:0] color_t;

    localparam color_t DEF_BG_HOME  = 8'h02;
    localparam color_t DEF_BG_PLAY  = 8'h00;
    localparam color_t DEF_BG_END   = 8'h60;
    localparam color_t DEF_C_PLAYER = 8'h1C;
    localparam color_t DEF_C_ENEMY  = 8'hE0;
    localparam color_t DEF_C_PROJ   = 8'hFC;

    typedef enum logic [1:0] {
        HOME   = 2'd0,
        UPDATE = 2'd1,
        END    = 2'd2
    } game_state_e;

    typedef struct packed {
        logic proj;
        logic player;
        logic e1;
        logic e2;
        logic e3;
    } hits_t;

    // Encoding 3 is not a real game state and falls back to HOME.
    function automatic game_state_e decode_state(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_state = UPDATE;
            2'd2:    decode_state = END;
            default: decode_state = HOME;
        endcase
    endfunction

endpackage

// File: rtl/game_pixel_renderer_if.sv
// Pixel request/response bus between the VGA driver (master) and the renderer (slave).
interface game_pixel_renderer_if;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [7:0] color_in;

    modport master (output next_x, output next_y, input  color_in);
    modport slave  (input  next_x, input  next_y, output color_in);
endinterface

// File: rtl/sprite_hit.sv
// Combinational inclusive-rectangle test on the game grid, clipped to the grid.
module sprite_hit
    import render_pkg::*;
(
    input  logic [7:0] gx,
    input  logic [7:0] gy,
    input  logic [7:0] left,
    input  logic [7:0] top,
    input  logic [3:0] w,
    input  logic [3:0] h,
    input  logic       en,
    output logic       hit
);

    localparam logic [8:0] GRID_W9 = 9'(GRID_W);
    localparam logic [8:0] GRID_H9 = 9'(GRID_H);

    logic [8:0] right;
    logic [8:0] bottom;
    logic       in_x;
    logic       in_y;

    // Nine-bit bounds so a sprite near column 255 cannot wrap back to column 0.
    assign right  = {1'b0, left} + {5'b0, w} - 9'd1;
    assign bottom = {1'b0, top}  + {5'b0, h} - 9'd1;

    assign in_x = ({1'b0, gx} >= {1'b0, left}) && ({1'b0, gx} <= right)  && ({1'b0, gx} < GRID_W9);
    assign in_y = ({1'b0, gy} >= {1'b0, top})  && ({1'b0, gy} <= bottom) && ({1'b0, gy} < GRID_H9);

    assign hit = en && in_x && in_y;

endmodule

// File: rtl/game_pixel_renderer.sv
// Two-stage pixel compositor: per-frame snapshot of object positions, hit test, priority mux.
module game_pixel_renderer
    import render_pkg::*;
#(
    parameter int     SPRITE_W = 8,
    parameter int     SPRITE_H = 4,
    parameter int     PLAYER_Y = 119,
    parameter color_t BG_HOME  = DEF_BG_HOME,
    parameter color_t BG_PLAY  = DEF_BG_PLAY,
    parameter color_t BG_END   = DEF_BG_END,
    parameter color_t C_PLAYER = DEF_C_PLAYER,
    parameter color_t C_ENEMY  = DEF_C_ENEMY,
    parameter color_t C_PROJ   = DEF_C_PROJ
) (
    input  logic                        clk,
    input  logic                        rst,
    game_pixel_renderer_if.slave        pix,
    input  logic                        frame_start,
    input  logic [1:0]                  game_state,
    input  logic [7:0]                  user_x,
    input  logic [23:0]                 enemy_x,
    input  logic [23:0]                 enemy_y,
    input  logic [2:0]                  enemy_alive,
    input  logic [7:0]                  projectile_x,
    input  logic [7:0]                  projectile_y,
    input  logic                        projectile_exists,
    output logic [5:0]                  frame_cnt
);

    localparam logic [7:0] PLAYER_TOP = 8'(PLAYER_Y - SPRITE_H + 1);
    localparam logic [3:0] SW         = 4'(SPRITE_W);
    localparam logic [3:0] SH         = 4'(SPRITE_H);

    game_state_e state_q, state_d;

    logic [7:0] sh_user_x;
    logic [7:0] sh_ex [3];
    logic [7:0] sh_ey [3];
    logic [2:0] sh_alive;
    logic [7:0] sh_px;
    logic [7:0] sh_py;
    logic       sh_pexists;
    logic [5:0] frame_cnt_q;

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (frame_start) state_d = decode_state(game_state);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= HOME;
        else     state_q <= state_d;
    end

    // NOTE: the shadows are reset explicitly so a reset never leaves a partial snapshot on screen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_user_x   <= '0;
            sh_alive    <= '0;
            sh_px       <= '0;
            sh_py       <= '0;
            sh_pexists  <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                sh_ex[i] <= '0;
                sh_ey[i] <= '0;
            end
        end else if (frame_start) begin
            sh_user_x   <= user_x;
            sh_alive    <= enemy_alive;
            sh_px       <= projectile_x;
            sh_py       <= projectile_y;
            sh_pexists  <= projectile_exists;
            frame_cnt_q <= frame_cnt_q + 6'd1;
            for (int i = 0; i < 3; i++) begin
                sh_ex[i] <= enemy_x[i*8 +: 8];
                sh_ey[i] <= enemy_y[i*8 +: 8];
            end
        end
    end

    assign frame_cnt = frame_cnt_q;

    logic [7:0] gx, gy;
    logic       off_screen;
    logic       draw_all;
    logic       player_vis;
    hits_t      hits_d;
    color_t     bg_d;

    assign gx         = pix.next_x[9:2];
    assign gy         = pix.next_y[9:2];
    assign off_screen = (pix.next_x >= 10'(H_ACTIVE)) || (pix.next_y >= 10'(V_ACTIVE));
    assign draw_all   = (state_q != HOME);
    assign player_vis = !((state_q == END) && frame_cnt_q[4]);

    sprite_hit u_hit_player (
        .gx(gx), .gy(gy), .left(sh_user_x), .top(PLAYER_TOP),
        .w(SW), .h(SH), .en(player_vis), .hit(hits_d.player)
    );

    sprite_hit u_hit_e1 (
        .gx(gx), .gy(gy), .left(sh_ex[0]), .top(sh_ey[0]),
        .w(SW), .h(SH), .en(sh_alive[0] && draw_all), .hit(hits_d.e1)
    );

    sprite_hit u_hit_e2 (
        .gx(gx), .gy(gy), .left(sh_ex[1]), .top(sh_ey[1]),
        .w(SW), .h(SH), .en(sh_alive[1] && draw_all), .hit(hits_d.e2)
    );

    sprite_hit u_hit_e3 (
        .gx(gx), .gy(gy), .left(sh_ex[2]), .top(sh_ey[2]),
        .w(SW), .h(SH), .en(sh_alive[2] && draw_all), .hit(hits_d.e3)
    );

    sprite_hit u_hit_proj (
        .gx(gx), .gy(gy), .left(sh_px), .top(sh_py),
        .w(4'd1), .h(4'd2), .en(sh_pexists && draw_all), .hit(hits_d.proj)
    );

    always_comb begin
        bg_d = BG_HOME;
        case (state_q)
            UPDATE:  bg_d = BG_PLAY;
            END:     bg_d = BG_END;
            default: bg_d = BG_HOME;
        endcase
    end

    logic   s1_off;
    hits_t  s1_hits;
    color_t s1_bg;
    color_t color_d;
    color_t color_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_off  <= 1'b0;
            s1_hits <= '0;
            s1_bg   <= '0;
        end else begin
            s1_off  <= off_screen;
            s1_hits <= hits_d;
            s1_bg   <= bg_d;
        end
    end

    always_comb begin
        color_d = s1_bg;
        if      (s1_off)         color_d = 8'h00;
        else if (s1_hits.proj)   color_d = C_PROJ;
        else if (s1_hits.player) color_d = C_PLAYER;
        else if (s1_hits.e1)     color_d = C_ENEMY;
        else if (s1_hits.e2)     color_d = C_ENEMY;
        else if (s1_hits.e3)     color_d = C_ENEMY;
    end

    always_ff @(posedge clk) begin
        if (rst) color_q <= 8'h00;
        else     color_q <= color_d;
    end

    assign pix.color_in = color_q;

endmodule

// File: tb/tb_game_pixel_renderer.sv
// Directed self-checking bench for game_pixel_renderer with hand-computed expected colors.
module tb_game_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [1:0]  game_state;
    logic [7:0]  user_x;
    logic [23:0] enemy_x;
    logic [23:0] enemy_y;
    logic [2:0]  enemy_alive;
    logic [7:0]  projectile_x;
    logic [7:0]  projectile_y;
    logic        projectile_exists;
    logic [5:0]  frame_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] exp_fcnt = '0;
    int         n_player = 0;

    game_pixel_renderer_if pix ();

    game_pixel_renderer dut (
        .clk              (clk),
        .rst              (rst),
        .pix              (pix),
        .frame_start      (frame_start),
        .game_state       (game_state),
        .user_x           (user_x),
        .enemy_x          (enemy_x),
        .enemy_y          (enemy_y),
        .enemy_alive      (enemy_alive),
        .projectile_x     (projectile_x),
        .projectile_y     (projectile_y),
        .projectile_exists(projectile_exists),
        .frame_cnt        (frame_cnt)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        exp_fcnt = exp_fcnt + 6'd1;
        check("frame_cnt", {2'b00, frame_cnt}, {2'b00, exp_fcnt});
    endtask

    task automatic req(input string tag, input int x, input int y, input logic [7:0] exp);
        @(negedge clk);
        pix.next_x = 10'(x);
        pix.next_y = 10'(y);
        @(posedge clk);
        @(posedge clk);
        #1;
        check(tag, pix.color_in, exp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        frame_start       = 1'b0;
        game_state        = 2'd0;
        user_x            = '0;
        enemy_x           = '0;
        enemy_y           = '0;
        enemy_alive       = '0;
        projectile_x      = '0;
        projectile_y      = '0;
        projectile_exists = 1'b0;
        pix.next_x        = '0;
        pix.next_y        = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_color", pix.color_in, 8'h00);
        check("reset_fcnt", {2'b00, frame_cnt}, 8'h00);
        @(negedge clk) rst = 1'b0;

        // Empty playfield in UPDATE.
        game_state = 2'd1;
        pulse();
        req("empty_origin", 0, 0, 8'h00);
        req("offscreen_x", 700, 10, 8'h00);

        // Player at column 10.
        user_x = 8'd10;
        pulse();
        req("player_left", 40, 464, 8'h1C);
        req("player_left_m1", 39, 464, 8'h00);
        req("player_right_p1", 72, 464, 8'h00);
        req("player_right", 68, 476, 8'h1C);

        // Projectile over the player, overlapping enemies.
        projectile_x      = 8'd12;
        projectile_y      = 8'd116;
        projectile_exists = 1'b1;
        enemy_x           = {8'd0, 8'd50, 8'd50};
        enemy_y           = {8'd0, 8'd50, 8'd50};
        enemy_alive       = 3'b011;
        pulse();
        req("proj_over_player", 48, 468, 8'hFC);
        req("proj_lower_row", 48, 471, 8'hFC);
        req("enemy_overlap", 200, 200, 8'hE0);
        req("enemy_bottom_p1", 200, 216, 8'h00);

        // Mid-frame change is invisible until the next snapshot.
        user_x = 8'd40;
        req("no_tear", 40, 464, 8'h1C);
        pulse();
        req("after_snap_old", 40, 464, 8'h00);
        req("after_snap_new", 160, 464, 8'h1C);

        // Right grid edge clipping.
        user_x = 8'd156;
        pulse();
        req("edge_last_col", 636, 464, 8'h1C);
        req("edge_offscreen", 640, 464, 8'h00);
        req("edge_before", 620, 464, 8'h00);
        req("edge_top_m1", 636, 460, 8'h00);

        // END: player blinks with frame_cnt[4].
        user_x     = 8'd10;
        game_state = 2'd2;
        for (int f = 0; f < 32; f++) begin
            pulse();
            req("end_blink", 40, 464, exp_fcnt[4] ? 8'h60 : 8'h1C);
            if (!exp_fcnt[4]) n_player++;
        end
        check("blink_visible_frames", 8'(n_player), 8'd16);
        req("end_enemy", 200, 200, 8'hE0);
        do pulse(); while (exp_fcnt != 6'd0);

        // HOME suppresses enemies and projectile.
        projectile_x = 8'd100;
        projectile_y = 8'd60;
        game_state   = 2'd3;
        pulse();
        req("home_enemy_hidden", 200, 200, 8'h02);
        req("home_proj_hidden", 400, 240, 8'h02);
        req("home_player", 40, 464, 8'h1C);

        // Reset while requests stream.
        game_state = 2'd1;
        pulse();
        @(negedge clk);
        pix.next_x = 10'd400;
        pix.next_y = 10'd240;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out0", pix.color_in, 8'h00);
        check("rst_fcnt", {2'b00, frame_cnt}, 8'h00);
        exp_fcnt = '0;
        @(negedge clk);
        rst        = 1'b0;
        pix.next_x = 10'd40;
        pix.next_y = 10'd464;
        @(posedge clk);
        #1;
        check("rst_out1", pix.color_in, 8'h00);
        @(posedge clk);
        #1;
        check("rst_shadow_home", pix.color_in, 8'h02);
        req("rst_player_at0", 0, 464, 8'h1C);
        req("rst_proj_gone", 400, 240, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
